coco_mdu: RTL and testbench

- Parametrised multi-cycle multiply/divide unit with architectural HI/LO registers; the sequential companion to the single-cycle integer ALU in the execute stage.
- Runs MULT/MULTU/DIV/DIVU iteratively, one bit per cycle, and handles the single-cycle MTHI/MTLO writes.
- The pipeline stalls on busy, reads hi/lo directly, and aborts an in-flight operation with flush on an exception.

---
 rtl/coco_mdu_pkg.sv | 40 ++++
 rtl/coco_mdu_step.sv | 37 +++
 rtl/coco_mdu.sv | 136 +++++++++++++
 tb/tb_coco_mdu.sv | 250 +++++++++++++++++++++++++
 4 files changed

// File: rtl/coco_mdu_pkg.sv
// Shared encodings for the multiply/divide unit: op codes, FSM states, op classification helpers.
// Latency: n/a (constants and pure functions only).
// Backpressure: n/a. MADD/MADDU/MSUB/MSUBU count as long ops only when COCO_MDU_MADD_EN is defined.
package coco_mdu_pkg;

    localparam logic [3:0] OP_MULT  = 4'd0;
    localparam logic [3:0] OP_MULTU = 4'd1;
    localparam logic [3:0] OP_DIV   = 4'd2;
    localparam logic [3:0] OP_DIVU  = 4'd3;
    localparam logic [3:0] OP_MTHI  = 4'd4;
    localparam logic [3:0] OP_MTLO  = 4'd5;
    localparam logic [3:0] OP_MADD  = 4'd6;
    localparam logic [3:0] OP_MADDU = 4'd7;
    localparam logic [3:0] OP_MSUB  = 4'd8;
    localparam logic [3:0] OP_MSUBU = 4'd9;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_CALC = 2'd1;
    localparam logic [1:0] ST_FIX  = 2'd2;

    // Ops that run the iterative datapath and end with a done pulse.
    function automatic logic is_mdu_long_op(input logic [3:0] op);
        logic r;
        r = (op == OP_MULT) || (op == OP_MULTU) || (op == OP_DIV) || (op == OP_DIVU);
`ifdef COCO_MDU_MADD_EN
        r = r || (op == OP_MADD) || (op == OP_MADDU) || (op == OP_MSUB) || (op == OP_MSUBU);
`endif
        return r;
    endfunction

    // Ops whose operands are two's complement and need magnitude/sign handling.
    function automatic logic is_signed_op(input logic [3:0] op);
        return (op == OP_MULT) || (op == OP_DIV) || (op == OP_MADD) || (op == OP_MSUB);
    endfunction

    function automatic logic is_div_op(input logic [3:0] op);
        return (op == OP_DIV) || (op == OP_DIVU);
    endfunction

endpackage

// File: rtl/coco_mdu_step.sv
// One iteration of the unsigned datapath: shift-add multiply or restoring shift-subtract divide.
// Latency: combinational.
// Backpressure: none; the caller decides when to register pr_next.
module coco_mdu_step #(
    parameter int WIDTH = 32
) (
    input  logic                 is_div,
    input  logic [2*WIDTH-1:0]   pr,
    input  logic [WIDTH-1:0]     mcand,
    output logic [2*WIDTH-1:0]   pr_next
);

    logic [WIDTH:0]   sum;
    logic [2*WIDTH:0] shl;
    logic [WIDTH:0]   trial;

    // Multiply: upper half accumulates, lower half holds the multiplier and shifts out LSB-first.
    // Divide: upper half is the partial remainder, quotient bits shift into the lower half.
    always_comb begin
        sum     = {1'b0, pr[2*WIDTH-1:WIDTH]} + {1'b0, mcand};
        shl     = {pr, 1'b0};
        trial   = shl[2*WIDTH:WIDTH] - {1'b0, mcand};
        pr_next = pr;
        if (is_div) begin
            pr_next = shl[2*WIDTH-1:0];
            // No borrow means the divisor fits: keep the difference and emit a 1 quotient bit.
            if (!trial[WIDTH]) begin
                pr_next = {trial[WIDTH-1:0], shl[WIDTH-1:1], 1'b1};
            end
        end else if (pr[0]) begin
            pr_next = {sum, pr[WIDTH-1:1]};
        end else begin
            pr_next = {1'b0, pr[2*WIDTH-1:1]};
        end
    end

endmodule

// File: rtl/coco_mdu.sv
// Iterative MULT/MULTU/DIV/DIVU unit with HI/LO registers and single-cycle MTHI/MTLO; optional MADD* via COCO_MDU_MADD_EN.
// Latency: done pulses WIDTH+1 edges after the accept edge, independent of operand values.
// Backpressure: busy holds off new starts (ignored while busy); flush aborts without touching HI/LO.
module coco_mdu
    import coco_mdu_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int CNT_W = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [3:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             flush,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    logic [1:0]           state;
    logic [CNT_W-1:0]     cnt;
    logic [3:0]           op_q;
    logic [2*WIDTH-1:0]   pr;
    logic [WIDTH-1:0]     mcand;
    logic                 neg_q;
    logic                 neg_r;

    logic [2*WIDTH-1:0]   pr_next;
    logic                 a_neg;
    logic                 b_neg;
    logic [WIDTH-1:0]     a_mag;
    logic [WIDTH-1:0]     b_mag;
    logic [2*WIDTH-1:0]   res;

    assign busy = (state != ST_IDLE);

    coco_mdu_step #(.WIDTH(WIDTH)) u_step (
        .is_div  (is_div_op(op_q)),
        .pr      (pr),
        .mcand   (mcand),
        .pr_next (pr_next)
    );

    // Operand magnitudes and signs; unsigned ops see both signs as zero.
    always_comb begin
        a_neg = is_signed_op(op) && a[WIDTH-1];
        b_neg = is_signed_op(op) && b[WIDTH-1];
        a_mag = a_neg ? -a : a;
        b_mag = b_neg ? -b : b;
    end

    // Final HI/LO value written on the FIX edge: sign-correct the magnitude result, optionally accumulate.
    always_comb begin
        if (is_div_op(op_q)) begin
            res = {(neg_r ? -pr[2*WIDTH-1:WIDTH] : pr[2*WIDTH-1:WIDTH]),
                   (neg_q ? -pr[WIDTH-1:0]       : pr[WIDTH-1:0])};
        end else begin
            res = neg_q ? -pr : pr;
        end
`ifdef COCO_MDU_MADD_EN
        if ((op_q == OP_MADD) || (op_q == OP_MADDU)) begin
            res = {hi, lo} + res;
        end else if ((op_q == OP_MSUB) || (op_q == OP_MSUBU)) begin
            res = {hi, lo} - res;
        end
`endif
    end

    // Control FSM, iteration counter, datapath registers and architectural HI/LO.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_IDLE;
            cnt   <= '0;
            op_q  <= OP_MULT;
            pr    <= '0;
            mcand <= '0;
            neg_q <= 1'b0;
            neg_r <= 1'b0;
            done  <= 1'b0;
            hi    <= '0;
            lo    <= '0;
        end else begin
            done <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (start && !flush) begin
                        if (is_mdu_long_op(op)) begin
                            state <= ST_CALC;
                            cnt   <= '0;
                            op_q  <= op;
                            neg_r <= a_neg;
                            if (is_div_op(op)) begin
                                pr    <= {{WIDTH{1'b0}}, a_mag};
                                mcand <= b_mag;
                                // A zero divisor must yield an all-ones quotient, so never negate it.
                                neg_q <= (a_neg ^ b_neg) && (b != '0);
                            end else begin
                                pr    <= {{WIDTH{1'b0}}, b_mag};
                                mcand <= a_mag;
                                neg_q <= a_neg ^ b_neg;
                            end
                        end else if (op == OP_MTHI) begin
                            hi <= a;
                        end else if (op == OP_MTLO) begin
                            lo <= a;
                        end
                    end
                end
                ST_CALC: begin
                    if (flush) begin
                        state <= ST_IDLE;
                    end else begin
                        pr <= pr_next;
                        if (cnt == CNT_W'(WIDTH - 1)) begin
                            state <= ST_FIX;
                        end else begin
                            cnt <= cnt + CNT_W'(1);
                        end
                    end
                end
                ST_FIX: begin
                    state <= ST_IDLE;
                    if (!flush) begin
                        {hi, lo} <= res;
                        done     <= 1'b1;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_coco_mdu.sv
// Self-checking bench for coco_mdu (WIDTH=32): directed plan steps plus randomized ops vs. an arithmetic model.
// Latency: checks done arrives exactly 33 edges after accept.
// Backpressure: exercises start-while-busy, flush in CALC/FIX, start+flush, and async reset mid-operation.
module tb_coco_mdu;
    import coco_mdu_pkg::*;

    logic        clk;
    logic        rst_n;
    logic        start;
    logic [3:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic        flush;
    logic        busy;
    logic        done;
    logic [31:0] hi;
    logic [31:0] lo;

    int n_cmp = 0;
    int n_err = 0;

    logic [31:0] m_hi;
    logic [31:0] m_lo;

    coco_mdu dut (
        .clk   (clk),
        .rst_n (rst_n),
        .start (start),
        .op    (op),
        .a     (a),
        .b     (b),
        .flush (flush),
        .busy  (busy),
        .done  (done),
        .hi    (hi),
        .lo    (lo)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Architectural result of one op, computed with plain 64-bit arithmetic.
    task automatic model(input logic [3:0] o, input logic [31:0] x, input logic [31:0] y,
                         input logic [31:0] ch, input logic [31:0] cl,
                         output logic [31:0] nh, output logic [31:0] nl, output bit long_op);
        longint      sx;
        longint      sy;
        logic [63:0] p;
        sx = longint'($signed(x));
        sy = longint'($signed(y));
        nh = ch;
        nl = cl;
        long_op = 1'b0;
        case (o)
            OP_MULT:  begin p = 64'(sx * sy); {nh, nl} = p; long_op = 1'b1; end
            OP_MULTU: begin p = {32'd0, x} * {32'd0, y}; {nh, nl} = p; long_op = 1'b1; end
            OP_DIV: begin
                long_op = 1'b1;
                if (y == 32'd0) begin nh = x; nl = 32'hFFFF_FFFF; end
                else begin nl = 32'(sx / sy); nh = 32'(sx % sy); end
            end
            OP_DIVU: begin
                long_op = 1'b1;
                if (y == 32'd0) begin nh = x; nl = 32'hFFFF_FFFF; end
                else begin nl = x / y; nh = x % y; end
            end
            OP_MTHI: nh = x;
            OP_MTLO: nl = x;
`ifdef COCO_MDU_MADD_EN
            OP_MADD:  begin p = {ch, cl} + 64'(sx * sy); {nh, nl} = p; long_op = 1'b1; end
            OP_MSUB:  begin p = {ch, cl} - 64'(sx * sy); {nh, nl} = p; long_op = 1'b1; end
            OP_MADDU: begin p = {ch, cl} + {32'd0, x} * {32'd0, y}; {nh, nl} = p; long_op = 1'b1; end
            OP_MSUBU: begin p = {ch, cl} - {32'd0, x} * {32'd0, y}; {nh, nl} = p; long_op = 1'b1; end
`endif
            default: ;
        endcase
    endtask

    // Issue one op as soon as the unit is idle; optionally flush or poke a second start at a given cycle.
    task automatic do_op(input logic [3:0] o, input logic [31:0] x, input logic [31:0] y,
                         input int flush_cyc, input int poke_cyc);
        logic [31:0] eh;
        logic [31:0] el;
        bit          long_op;
        int          done_cyc;
        bit          busy_ok;
        bit          seen;
        for (int i = 0; i < 50 && busy; i++) begin @(posedge clk); #1; end
        check("idle_before_start", busy, 0);
        model(o, x, y, m_hi, m_lo, eh, el, long_op);
        start = 1'b1; op = o; a = x; b = y;
        @(posedge clk); #1;
        start = 1'b0;
        if (!long_op) begin
            check("short_busy", busy, 0);
            check("short_done", done, 0);
            m_hi = eh; m_lo = el;
            check("short_hi", hi, m_hi);
            check("short_lo", lo, m_lo);
            return;
        end
        done_cyc = 0;
        busy_ok  = 1'b1;
        for (int c = 1; c <= 40 && done_cyc == 0; c++) begin
            if (c == flush_cyc) flush = 1'b1;
            if (c == poke_cyc) begin start = 1'b1; op = OP_DIVU; a = $urandom; b = $urandom; end
            @(posedge clk); #1;
            flush = 1'b0;
            start = 1'b0;
            if (flush_cyc != 0 && c == flush_cyc) begin
                check("flush_busy", busy, 0);
                check("flush_done", done, 0);
                seen = 1'b0;
                for (int k = 0; k < 40; k++) begin @(posedge clk); #1; if (done) seen = 1'b1; end
                check("flush_no_done", seen, 0);
                check("flush_hi", hi, m_hi);
                check("flush_lo", lo, m_lo);
                return;
            end
            if (done) done_cyc = c;
            else if (!busy) busy_ok = 1'b0;
        end
        check("latency", done_cyc, 33);
        check("busy_held", busy_ok, 1);
        check("busy_at_done", busy, 0);
        m_hi = eh; m_lo = el;
        check("hi", hi, m_hi);
        check("lo", lo, m_lo);
    endtask

    function automatic logic [31:0] pick();
        logic [31:0] corners [5];
        corners = '{32'd0, 32'd1, 32'hFFFF_FFFF, 32'h8000_0000, 32'h7FFF_FFFF};
        case ($urandom_range(0, 2))
            0:       return $urandom;
            1:       return $urandom_range(0, 20);
            default: return corners[$urandom_range(0, 4)];
        endcase
    endfunction

    initial begin
        bit seen;
        rst_n = 1'b0; start = 1'b0; op = 4'd0; a = '0; b = '0; flush = 1'b0;
        m_hi = '0; m_lo = '0;
        #12;
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_hi", hi, 0);
        check("rst_lo", lo, 0);
        rst_n = 1'b1;
        @(posedge clk); #1;

        // Directed plan steps.
        do_op(OP_MULT, 32'hFFFF_FFFE, 32'd3, 0, 0);
        check("mult_hi_const", hi, 32'hFFFF_FFFF);
        check("mult_lo_const", lo, 32'hFFFF_FFFA);
        @(posedge clk); #1;
        check("done_one_cycle", done, 0);
        do_op(OP_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0, 0);
        check("multu_hi_const", hi, 32'hFFFF_FFFE);
        check("multu_lo_const", lo, 32'h0000_0001);
        do_op(OP_DIV, 32'hFFFF_FFF9, 32'd2, 0, 0);
        check("div_lo_const", lo, 32'hFFFF_FFFD);
        check("div_hi_const", hi, 32'hFFFF_FFFF);
        do_op(OP_DIVU, 32'd7, 32'd0, 0, 0);
        check("divz_lo_const", lo, 32'hFFFF_FFFF);
        check("divz_hi_const", hi, 32'd7);
        do_op(OP_DIV, 32'd7, 32'd0, 0, 0);
        do_op(OP_DIV, 32'hFFFF_FFF9, 32'd0, 0, 0);
        check("sdivz_lo_const", lo, 32'hFFFF_FFFF);
        do_op(OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 0, 0);
        check("ovf_lo_const", lo, 32'h8000_0000);
        check("ovf_hi_const", hi, 32'd0);

        do_op(OP_MTHI, 32'h1234, 32'd0, 0, 0);
        do_op(OP_MULTU, 32'd5, 32'd6, 10, 0);
        check("flush_hi_const", hi, 32'h1234);
        do_op(OP_MULTU, 32'd9, 32'd9, 33, 0);

        start = 1'b1; flush = 1'b1; op = OP_MULTU; a = 32'd5; b = 32'd6;
        @(posedge clk); #1;
        start = 1'b0; flush = 1'b0;
        check("startflush_busy", busy, 0);
        seen = 1'b0;
        for (int k = 0; k < 40; k++) begin @(posedge clk); #1; if (done) seen = 1'b1; end
        check("startflush_no_done", seen, 0);
        check("startflush_lo", lo, m_lo);

        do_op(OP_MULTU, 32'd5, 32'd6, 0, 3);
        check("poke_lo_const", lo, 32'd30);
        do_op(OP_DIVU, 32'd30, 32'd4, 0, 0);
        check("b2b_lo_const", lo, 32'd7);
        check("b2b_hi_const", hi, 32'd2);

`ifdef COCO_MDU_MADD_EN
        do_op(OP_MTHI, 32'd0, 32'd0, 0, 0);
        do_op(OP_MTLO, 32'd1, 32'd0, 0, 0);
        do_op(OP_MADD, 32'd2, 32'd3, 0, 0);
        check("madd_lo_const", lo, 32'd7);
        do_op(OP_MSUBU, 32'd1, 32'd8, 0, 0);
        check("msubu_hi_const", hi, 32'hFFFF_FFFF);
        check("msubu_lo_const", lo, 32'hFFFF_FFFF);
`else
        do_op(OP_MADD, 32'd2, 32'd3, 0, 0);
        do_op(OP_MSUBU, 32'd1, 32'd8, 0, 0);
`endif
        do_op(4'd15, 32'hDEAD, 32'hBEEF, 0, 0);

        // Randomized ops against the model, with occasional flushes.
        for (int n = 0; n < 40; n++) begin
            logic [3:0] ro;
            int         fc;
            ro = 4'($urandom_range(0, 9));
            fc = ($urandom_range(0, 7) == 0) ? int'($urandom_range(1, 33)) : 0;
            do_op(ro, pick(), pick(), fc, 0);
        end

        // Asynchronous reset in the middle of an operation clears everything at once.
        do_op(OP_MTLO, 32'h55, 32'd0, 0, 0);
        start = 1'b1; op = OP_MULT; a = 32'd123; b = 32'd456;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (5) @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        m_hi = '0; m_lo = '0;
        check("midrst_busy", busy, 0);
        check("midrst_hi", hi, m_hi);
        check("midrst_lo", lo, m_lo);
        #3;
        rst_n = 1'b1;
        seen = 1'b0;
        for (int k = 0; k < 40; k++) begin @(posedge clk); #1; if (done) seen = 1'b1; end
        check("midrst_no_done", seen, 0);
        do_op(OP_DIVU, 32'd100, 32'd7, 0, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
